dm_arbiter: RTL and testbench

Two-port arbiter and access sequencer for the BIP-2 single-port data memory (RAM block: WR, 11-bit address, 11-bit write data, combinational 11-bit read data).

- Port 0 serves the CPU data path; port 1 serves the program/IO loader.
- Each access is granted round-robin, registered, driven onto the RAM for exactly one cycle, and acknowledged with the read data captured.
- The arbiter is the only driver of the RAM WR, address and data inputs.

---
 rtl/dm_arbiter.sv | 141 ++++++++++++++
 tb/tb_dm_arbiter.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/dm_arbiter.sv
// Two-port round-robin arbiter and one-cycle access sequencer for the BIP-2 data memory.
// Port 0 is the CPU data path and port 1 is the program/IO loader. Every access runs IDLE -> ACCESS -> RESP.
module dm_arbiter #(
    parameter int ADDR_W = 11,
    parameter int DATA_W = 11
) (
    input  logic              CLK_i,
    input  logic              RST_i,
    input  logic              REQ0_i,
    input  logic              WE0_i,
    input  logic [ADDR_W-1:0] ADDR0_i,
    input  logic [DATA_W-1:0] WDATA0_i,
    input  logic              REQ1_i,
    input  logic              WE1_i,
    input  logic [ADDR_W-1:0] ADDR1_i,
    input  logic [DATA_W-1:0] WDATA1_i,
    output logic              ACK0_o,
    output logic              ACK1_o,
    output logic [DATA_W-1:0] RDATA0_o,
    output logic [DATA_W-1:0] RDATA1_o,
    output logic              RAM_WR_o,
    output logic [ADDR_W-1:0] RAM_ADDR_o,
    output logic [DATA_W-1:0] RAM_DATA_o,
    input  logic [DATA_W-1:0] RAM_RDATA_i,
    output logic              BUSY_o
);

    // state  | meaning
    // IDLE   | waiting for a request; the only state that samples requester inputs
    // ACCESS | command registers drive the RAM; WR is high for a write
    // RESP   | ACK pulse to the served port; always returns to IDLE
    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_RESP   = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic                last_grant_q, last_grant_d;
    logic                gnt_q, gnt_d;
    logic                we_q, we_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic                wr_q, wr_d;
    logic                ack0_q, ack0_d;
    logic                ack1_q, ack1_d;
    logic                busy_q, busy_d;
    logic [DATA_W-1:0]   rdata0_q, rdata0_d;
    logic [DATA_W-1:0]   rdata1_q, rdata1_d;
    logic                win;

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        gnt_d        = gnt_q;
        we_d         = we_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        wr_d         = 1'b0;
        ack0_d       = 1'b0;
        ack1_d       = 1'b0;
        busy_d       = busy_q;
        rdata0_d     = rdata0_q;
        rdata1_d     = rdata1_q;
        win          = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (REQ0_i || REQ1_i) begin
                    // A tie goes to whichever port was not served last.
                    win          = (REQ0_i && REQ1_i) ? ~last_grant_q : REQ1_i;
                    gnt_d        = win;
                    last_grant_d = win;
                    we_d         = win ? WE1_i    : WE0_i;
                    addr_d       = win ? ADDR1_i  : ADDR0_i;
                    wdata_d      = win ? WDATA1_i : WDATA0_i;
                    wr_d         = win ? WE1_i    : WE0_i;
                    busy_d       = 1'b1;
                    state_d      = S_ACCESS;
                end
            end
            S_ACCESS: begin
                if (!we_q) begin
                    if (gnt_q) rdata1_d = RAM_RDATA_i;
                    else       rdata0_d = RAM_RDATA_i;
                end
                ack0_d  = ~gnt_q;
                ack1_d  = gnt_q;
                state_d = S_RESP;
            end
            S_RESP: begin
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
            default: begin
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK_i or posedge RST_i) begin
        if (RST_i) begin
            state_q      <= S_IDLE;
            last_grant_q <= 1'b1;
            gnt_q        <= 1'b0;
            we_q         <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            wr_q         <= 1'b0;
            ack0_q       <= 1'b0;
            ack1_q       <= 1'b0;
            busy_q       <= 1'b0;
            rdata0_q     <= '0;
            rdata1_q     <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            gnt_q        <= gnt_d;
            we_q         <= we_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            wr_q         <= wr_d;
            ack0_q       <= ack0_d;
            ack1_q       <= ack1_d;
            busy_q       <= busy_d;
            rdata0_q     <= rdata0_d;
            rdata1_q     <= rdata1_d;
        end
    end

    assign ACK0_o     = ack0_q;
    assign ACK1_o     = ack1_q;
    assign RDATA0_o   = rdata0_q;
    assign RDATA1_o   = rdata1_q;
    assign RAM_WR_o   = wr_q;
    assign RAM_ADDR_o = addr_q;
    assign RAM_DATA_o = wdata_q;
    assign BUSY_o     = busy_q;

endmodule

// File: tb/tb_dm_arbiter.sv
// Directed bench for dm_arbiter with an attached RAM and a transaction-level reference model.
// The model and the directed literal checks are both compared against the DUT.
module tb_dm_arbiter;

    logic        clk = 1'b0;
    logic        clk_en = 1'b0;
    logic        rst = 1'b0;
    logic        req0 = 1'b0, we0 = 1'b0, req1 = 1'b0, we1 = 1'b0;
    logic [10:0] addr0 = '0, wdata0 = '0, addr1 = '0, wdata1 = '0;
    logic        ack0, ack1, ram_wr, busy;
    logic [10:0] rdata0, rdata1, ram_addr, ram_data, ram_rdata;

    logic [10:0] ram [0:2047];
    int n_chk = 0;
    int n_fail = 0;

    dm_arbiter #(.ADDR_W(11), .DATA_W(11)) dut (
        .CLK_i(clk), .RST_i(rst),
        .REQ0_i(req0), .WE0_i(we0), .ADDR0_i(addr0), .WDATA0_i(wdata0),
        .REQ1_i(req1), .WE1_i(we1), .ADDR1_i(addr1), .WDATA1_i(wdata1),
        .ACK0_o(ack0), .ACK1_o(ack1), .RDATA0_o(rdata0), .RDATA1_o(rdata1),
        .RAM_WR_o(ram_wr), .RAM_ADDR_o(ram_addr), .RAM_DATA_o(ram_data),
        .RAM_RDATA_i(ram_rdata), .BUSY_o(busy)
    );

    always begin
        #5;
        if (clk_en) clk = ~clk;
    end

    always @(posedge clk) if (ram_wr) ram[ram_addr] <= ram_data;
    assign ram_rdata = ram[ram_addr];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: one transaction record, timed by edge count since the last reset.
    logic [10:0] mmem [0:2047];
    bit          m_init = 0;
    int          e = 0, t_start = 0, free_at = 1;
    bit          have = 0, lastg = 1, t_port = 0, t_we = 0;
    logic [10:0] t_addr = '0, t_data = '0, m_rd0 = '0, m_rd1 = '0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            e = 0; have = 0; free_at = 1; lastg = 1;
            m_rd0 = '0; m_rd1 = '0; t_addr = '0; t_data = '0; t_we = 0; t_port = 0;
            m_init = 1;
        end else begin
            e++;
            if (have && e == t_start + 1) begin
                if (t_we)        mmem[t_addr] = t_data;
                else if (t_port) m_rd1 = mmem[t_addr];
                else             m_rd0 = mmem[t_addr];
            end
            if (e >= free_at && (req0 || req1)) begin
                t_port  = (req0 && req1) ? !lastg : req1;
                lastg   = t_port;
                t_we    = t_port ? we1 : we0;
                t_addr  = t_port ? addr1 : addr0;
                t_data  = t_port ? wdata1 : wdata0;
                t_start = e;
                free_at = e + 3;
                have    = 1;
            end
        end
    end

    always @(negedge clk) begin
        if (m_init && !rst) begin
            chk("model_busy", busy, have && (e == t_start || e == t_start + 1));
            chk("model_wr",   ram_wr, have && e == t_start && t_we);
            chk("model_ack0", ack0, have && e == t_start + 1 && !t_port);
            chk("model_ack1", ack1, have && e == t_start + 1 && t_port);
            chk("model_addr", ram_addr, t_addr);
            chk("model_data", ram_data, t_data);
            chk("model_rd0",  rdata0, m_rd0);
            chk("model_rd1",  rdata1, m_rd1);
        end
    end

    task automatic do_req(input bit p, input bit we, input logic [10:0] a, input logic [10:0] d,
                          output int lat, output int wrc, output logic [10:0] wa, output logic [10:0] wd);
        bit got;
        lat = 0; wrc = 0; wa = '0; wd = '0; got = 0;
        @(negedge clk);
        if (p) begin req1 = 1; we1 = we; addr1 = a; wdata1 = d; end
        else   begin req0 = 1; we0 = we; addr0 = a; wdata0 = d; end
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            lat++;
            if (ram_wr) begin wrc++; wa = ram_addr; wd = ram_data; end
            if (p ? ack1 : ack0) got = 1;
        end
        if (!got) begin
            n_chk++; n_fail++;
            $display("FAIL ack_timeout: port %0d got no ACK within 20 cycles", p);
        end
        if (p) req1 = 0; else req0 = 0;
    endtask

    int          lat, wrc;
    logic [10:0] wa, wd;
    int          ack_port[$];
    int          ack_cyc[$];

    initial begin
        for (int i = 0; i < 2048; i++) begin ram[i] = '0; mmem[i] = '0; end
        ram[3] = 11'd701; mmem[3] = 11'd701;

        // 1: reset with no clock running
        #3 rst = 1;
        #1;
        chk("rst_wr", ram_wr, 0);   chk("rst_ack0", ack0, 0);  chk("rst_ack1", ack1, 0);
        chk("rst_busy", busy, 0);   chk("rst_rd0", rdata0, 0); chk("rst_rd1", rdata1, 0);
        chk("rst_addr", ram_addr, 0); chk("rst_data", ram_data, 0);
        clk_en = 1;
        @(negedge clk); @(negedge clk);
        rst = 0;
        for (int i = 0; i < 3; i++) begin @(negedge clk); chk("idle_busy", busy, 0); end

        // 2: port 0 write then read
        do_req(0, 1, 11'd1, 11'd2, lat, wrc, wa, wd);
        chk("p0w_lat", lat, 2); chk("p0w_wrc", wrc, 1); chk("p0w_addr", wa, 1); chk("p0w_data", wd, 2);
        do_req(0, 0, 11'd1, 11'd0, lat, wrc, wa, wd);
        chk("p0r_lat", lat, 2); chk("p0r_rdata", rdata0, 2); chk("p0r_wrc", wrc, 0);
        chk("p0_rd1_zero", rdata1, 0);

        // 3: port 1 read of preloaded location
        do_req(1, 0, 11'd3, 11'd0, lat, wrc, wa, wd);
        chk("p1r_rdata", rdata1, 701); chk("p1r_wrc", wrc, 0); chk("p1r_lat", lat, 2);

        // 4: continuous contention from reset release
        @(negedge clk); rst = 1;
        req0 = 1; we0 = 0; addr0 = 11'd1; req1 = 1; we1 = 0; addr1 = 11'd3;
        @(negedge clk); rst = 0;
        for (int i = 1; i <= 15; i++) begin
            @(negedge clk);
            chk("cont_one_ack", ack0 && ack1, 0);
            if (ack0) begin ack_port.push_back(0); ack_cyc.push_back(i); end
            if (ack1) begin ack_port.push_back(1); ack_cyc.push_back(i); end
        end
        chk("cont_nacks", ack_port.size(), 5);
        if (ack_port.size() >= 4) begin
            chk("cont_g0", ack_port[0], 0); chk("cont_g1", ack_port[1], 1);
            chk("cont_g2", ack_port[2], 0); chk("cont_g3", ack_port[3], 1);
            chk("cont_first", ack_cyc[0], 2);
            for (int i = 1; i < 4; i++) chk("cont_gap", ack_cyc[i] - ack_cyc[i-1], 3);
        end
        req0 = 0; req1 = 0;
        repeat (4) @(negedge clk);
        chk("cont_rd0", rdata0, 2); chk("cont_rd1", rdata1, 701);

        // 5: a write leaves the port's read data alone
        do_req(0, 0, 11'd1, 11'd0, lat, wrc, wa, wd);
        chk("wr_keep_pre", rdata0, 2);
        do_req(0, 1, 11'd7, 11'd5, lat, wrc, wa, wd);
        chk("wr_keep_ack", rdata0, 2); chk("wr7_addr", wa, 7); chk("wr7_data", wd, 5);
        repeat (3) @(negedge clk);
        chk("wr_keep_later", rdata0, 2);

        // 6: reset in the middle of a port 1 write
        @(negedge clk);
        req1 = 1; we1 = 1; addr1 = 11'd4; wdata1 = 11'd9;
        @(negedge clk);
        chk("mid_wr_high", ram_wr, 1);
        #2 rst = 1;
        #1;
        chk("mid_wr_drop", ram_wr, 0); chk("mid_busy_drop", busy, 0);
        chk("mid_ack1", ack1, 0);      chk("mid_rd0_clr", rdata0, 0);
        @(negedge clk);
        chk("mid_no_ack1", ack1, 0);
        rst = 0;
        lat = 0;
        begin
            bit got;
            got = 0;
            for (int i = 0; i < 20 && !got; i++) begin
                @(negedge clk);
                lat++;
                if (ack1) got = 1;
            end
            chk("mid_reissue_ack", got, 1);
        end
        chk("mid_reissue_lat", lat, 2);
        req1 = 0;
        do_req(0, 0, 11'd4, 11'd0, lat, wrc, wa, wd);
        chk("mid_readback", rdata0, 9);
        do_req(0, 0, 11'd7, 11'd0, lat, wrc, wa, wd);
        chk("addr7_readback", rdata0, 5);

        repeat (3) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
